// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register for the 64-bit LEGv8 pipeline.
// Registers the ALU result, store data, branch target and control bits into
// MEM, resolves B / CBZ / CBNZ / B.cond into a registered branch decision, and
// owns the architectural NZCV flag register written by ADDS/SUBS/ANDS.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               MEM busy: every register (NZCV included) holds
//   flush               squash the EX instruction; a bubble enters MEM
//   ex_valid            EX holds a real instruction
//   ex_alu_out          ALU result
//   ex_zero/negative/overflow/carry   ALU flags
//   ex_set_flags        instruction writes NZCV
//   ex_is_b/cbz/cbnz/bcond            branch type (at most one set)
//   ex_cond             B.cond condition code
//   ex_branch_target    computed branch target
//   ex_store_data       Rt value for STUR
//   ex_rd, ex_reg_write, ex_mem_read, ex_mem_write   destination / control
//   mem_*               registered copies presented to MEM
//   mem_branch_taken    registered branch decision
//   flags_nzcv          architectural flags {N,Z,C,V}
module ex_mem_stage #(
  parameter int WORD = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [WORD-1:0] ex_alu_out,
  input  logic            ex_zero,
  input  logic            ex_negative,
  input  logic            ex_overflow,
  input  logic            ex_carry,
  input  logic            ex_set_flags,
  input  logic            ex_is_b,
  input  logic            ex_is_cbz,
  input  logic            ex_is_cbnz,
  input  logic            ex_is_bcond,
  input  logic [3:0]      ex_cond,
  input  logic [WORD-1:0] ex_branch_target,
  input  logic [WORD-1:0] ex_store_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  output logic            mem_valid,
  output logic [WORD-1:0] mem_alu_out,
  output logic [WORD-1:0] mem_store_data,
  output logic [WORD-1:0] mem_branch_target,
  output logic [4:0]      mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_branch_taken,
  output logic [3:0]      flags_nzcv
);

  logic advance;
  logic bubble;
  logic cond_pass;
  logic taken_next;
  logic flag_n, flag_z, flag_c, flag_v;

  // Stall wins over flush: a flush seen during a stall is simply ignored,
  // the controller keeps it asserted until the pipeline can move.
  assign advance = ~stall & ~flush & ex_valid;
  assign bubble  = ~stall & (flush | ~ex_valid);

  assign {flag_n, flag_z, flag_c, flag_v} = flags_nzcv;

  // B.cond is judged against the committed flags of older instructions. A
  // setter immediately ahead has already written NZCV on the edge it left EX,
  // so no forwarding is required.
  always_comb begin
    cond_pass = 1'b0;
    case (ex_cond)
      4'd0:    cond_pass = flag_z;
      4'd1:    cond_pass = ~flag_z;
      4'd2:    cond_pass = flag_c;
      4'd3:    cond_pass = ~flag_c;
      4'd4:    cond_pass = flag_n;
      4'd5:    cond_pass = ~flag_n;
      4'd6:    cond_pass = flag_v;
      4'd7:    cond_pass = ~flag_v;
      4'd8:    cond_pass = flag_c & ~flag_z;
      4'd9:    cond_pass = ~(flag_c & ~flag_z);
      4'd10:   cond_pass = (flag_n == flag_v);
      4'd11:   cond_pass = (flag_n != flag_v);
      4'd12:   cond_pass = ~flag_z & (flag_n == flag_v);
      4'd13:   cond_pass = ~(~flag_z & (flag_n == flag_v));
      default: cond_pass = 1'b1;
    endcase
  end

  assign taken_next = ex_is_b
                    | (ex_is_cbz   &  ex_zero)
                    | (ex_is_cbnz  & ~ex_zero)
                    | (ex_is_bcond &  cond_pass);

  // Pipeline register. A bubble only clears the control bits; the data
  // fields are meaningless while mem_valid is low and are left alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid         <= 1'b0;
      mem_alu_out       <= '0;
      mem_store_data    <= '0;
      mem_branch_target <= '0;
      mem_rd            <= '0;
      mem_reg_write     <= 1'b0;
      mem_mem_read      <= 1'b0;
      mem_mem_write     <= 1'b0;
      mem_branch_taken  <= 1'b0;
    end else if (advance) begin
      mem_valid         <= 1'b1;
      mem_alu_out       <= ex_alu_out;
      mem_store_data    <= ex_store_data;
      mem_branch_target <= ex_branch_target;
      mem_rd            <= ex_rd;
      mem_reg_write     <= ex_reg_write;
      mem_mem_read      <= ex_mem_read;
      mem_mem_write     <= ex_mem_write;
      mem_branch_taken  <= taken_next;
    end else if (bubble) begin
      mem_valid         <= 1'b0;
      mem_reg_write     <= 1'b0;
      mem_mem_read      <= 1'b0;
      mem_mem_write     <= 1'b0;
      mem_branch_taken  <= 1'b0;
    end
  end

  // NZCV only changes when a flag-setting instruction actually leaves EX,
  // so flushed or stalled setters never disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_nzcv <= 4'b0000;
    end else if (advance && ex_set_flags) begin
      flags_nzcv <= {ex_negative, ex_zero, ex_carry, ex_overflow};
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
// Scoreboard bench for ex_mem_stage: each applied cycle computes the expected
// MEM-side state from a small reference model, queues it, and compares it
// against the DUT one edge later.
module tb_ex_mem_stage;

  localparam int WORD = 64;

  logic            clk = 1'b0;
  logic            rst, stall, flush, ex_valid;
  logic [WORD-1:0] ex_alu_out, ex_branch_target, ex_store_data;
  logic            ex_zero, ex_negative, ex_overflow, ex_carry, ex_set_flags;
  logic            ex_is_b, ex_is_cbz, ex_is_cbnz, ex_is_bcond;
  logic [3:0]      ex_cond;
  logic [4:0]      ex_rd;
  logic            ex_reg_write, ex_mem_read, ex_mem_write;
  logic            mem_valid;
  logic [WORD-1:0] mem_alu_out, mem_store_data, mem_branch_target;
  logic [4:0]      mem_rd;
  logic            mem_reg_write, mem_mem_read, mem_mem_write, mem_branch_taken;
  logic [3:0]      flags_nzcv;

  typedef struct packed {
    logic            chk_data;
    logic            valid;
    logic [WORD-1:0] alu_out;
    logic [WORD-1:0] store_data;
    logic [WORD-1:0] target;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            taken;
    logic [3:0]      nzcv;
  } exp_t;

  exp_t model;
  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  ex_mem_stage #(.WORD(WORD)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_out(ex_alu_out), .ex_zero(ex_zero), .ex_negative(ex_negative),
    .ex_overflow(ex_overflow), .ex_carry(ex_carry), .ex_set_flags(ex_set_flags),
    .ex_is_b(ex_is_b), .ex_is_cbz(ex_is_cbz), .ex_is_cbnz(ex_is_cbnz),
    .ex_is_bcond(ex_is_bcond), .ex_cond(ex_cond),
    .ex_branch_target(ex_branch_target), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .mem_valid(mem_valid),
    .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data),
    .mem_branch_target(mem_branch_target), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_branch_taken(mem_branch_taken),
    .flags_nzcv(flags_nzcv)
  );

  always #5 clk = ~clk;

  // Reference condition evaluation on {N,Z,C,V}.
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !(c && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [WORD-1:0] actual,
                             input logic [WORD-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Return all EX inputs to an idle, non-instruction state.
  task automatic clearInputs();
    stall = 0; flush = 0; ex_valid = 0; ex_alu_out = '0;
    ex_zero = 0; ex_negative = 0; ex_overflow = 0; ex_carry = 0;
    ex_set_flags = 0; ex_is_b = 0; ex_is_cbz = 0; ex_is_cbnz = 0;
    ex_is_bcond = 0; ex_cond = 4'd0; ex_branch_target = '0;
    ex_store_data = '0; ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0;
    ex_mem_write = 0;
  endtask

  // Present one ALU-type instruction with the given flags {N,Z,C,V}.
  task automatic setAlu(input logic [WORD-1:0] val, input logic [3:0] nzcv,
                        input logic setf);
    clearInputs();
    ex_valid = 1; ex_alu_out = val; ex_set_flags = setf;
    {ex_negative, ex_zero, ex_carry, ex_overflow} = nzcv;
    ex_rd = 5'd9; ex_reg_write = 1;
  endtask

  // Model the edge about to happen, queue the expectation, clock the DUT,
  // then pop the expectation and compare it with the DUT outputs.
  task automatic applyStimulus();
    exp_t nxt;
    exp_t got;
    nxt = model;
    if (rst) begin
      nxt = '0;
      nxt.chk_data = 1'b1;
    end else if (!stall) begin
      if (!flush && ex_valid) begin
        nxt.chk_data   = 1'b1;
        nxt.valid      = 1'b1;
        nxt.alu_out    = ex_alu_out;
        nxt.store_data = ex_store_data;
        nxt.target     = ex_branch_target;
        nxt.rd         = ex_rd;
        nxt.reg_write  = ex_reg_write;
        nxt.mem_read   = ex_mem_read;
        nxt.mem_write  = ex_mem_write;
        nxt.taken      = ex_is_b || (ex_is_cbz && ex_zero) ||
                         (ex_is_cbnz && !ex_zero) ||
                         (ex_is_bcond && cond_eval(ex_cond, model.nzcv));
        if (ex_set_flags) nxt.nzcv = {ex_negative, ex_zero, ex_carry, ex_overflow};
      end else begin
        nxt.chk_data  = 1'b0;
        nxt.valid     = 1'b0;
        nxt.reg_write = 1'b0;
        nxt.mem_read  = 1'b0;
        nxt.mem_write = 1'b0;
        nxt.taken     = 1'b0;
      end
    end
    model = nxt;
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    checkOutput("mem_valid", 64'(mem_valid), 64'(got.valid));
    checkOutput("mem_reg_write", 64'(mem_reg_write), 64'(got.reg_write));
    checkOutput("mem_mem_read", 64'(mem_mem_read), 64'(got.mem_read));
    checkOutput("mem_mem_write", 64'(mem_mem_write), 64'(got.mem_write));
    checkOutput("mem_branch_taken", 64'(mem_branch_taken), 64'(got.taken));
    checkOutput("flags_nzcv", 64'(flags_nzcv), 64'(got.nzcv));
    if (got.chk_data) begin
      checkOutput("mem_alu_out", mem_alu_out, got.alu_out);
      checkOutput("mem_store_data", mem_store_data, got.store_data);
      checkOutput("mem_branch_target", mem_branch_target, got.target);
      checkOutput("mem_rd", 64'(mem_rd), 64'(got.rd));
    end
  endtask

  initial begin
    int kind;
    model = '0;
    clearInputs();
    rst = 1;

    // Reset with inputs toggling and stall/flush wiggling.
    for (int i = 0; i < 4; i++) begin
      setAlu({$urandom, $urandom}, 4'($urandom), 1'b1);
      stall = i[0]; flush = i[1]; ex_is_b = 1; ex_mem_write = 1;
      applyStimulus();
    end
    checkOutput("reset_nzcv", 64'(flags_nzcv), 64'h0);
    checkOutput("reset_alu_out", mem_alu_out, 64'h0);
    rst = 0;

    // SUBS N=1 then B.cond LT -> taken.
    setAlu(64'hFFFF_FFFF_FFFF_FFF0, 4'b1000, 1'b1);
    applyStimulus();
    checkOutput("subs_nzcv", 64'(flags_nzcv), 64'h8);
    clearInputs(); ex_valid = 1; ex_is_bcond = 1; ex_cond = 4'd11;
    ex_branch_target = 64'h0000_0000_0000_1000;
    applyStimulus();
    checkOutput("blt_taken", 64'(mem_branch_taken), 64'h1);

    // Same with GE -> not taken.
    setAlu(64'hFFFF_FFFF_FFFF_FFF0, 4'b1000, 1'b1);
    applyStimulus();
    clearInputs(); ex_valid = 1; ex_is_bcond = 1; ex_cond = 4'd10;
    applyStimulus();
    checkOutput("bge_taken", 64'(mem_branch_taken), 64'h0);

    // CBZ / CBNZ with zero set.
    clearInputs(); ex_valid = 1; ex_is_cbz = 1; ex_zero = 1;
    ex_branch_target = 64'h0000_0000_0040_0ABC;
    applyStimulus();
    checkOutput("cbz_taken", 64'(mem_branch_taken), 64'h1);
    checkOutput("cbz_target", mem_branch_target, 64'h0000_0000_0040_0ABC);
    clearInputs(); ex_valid = 1; ex_is_cbnz = 1; ex_zero = 1;
    applyStimulus();
    checkOutput("cbnz_taken", 64'(mem_branch_taken), 64'h0);

    // ADD without set_flags leaves NZCV alone.
    setAlu(64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0);
    ex_is_cbnz = 0;
    applyStimulus();
    checkOutput("add_alu_out", mem_alu_out, 64'hFFFF_FFFF_FFFF_FFFF);

    // Flushed ADDS: bubble, flags untouched.
    setAlu(64'h0, 4'b0110, 1'b1);
    flush = 1; ex_mem_write = 1;
    applyStimulus();
    checkOutput("flush_valid", 64'(mem_valid), 64'h0);
    checkOutput("flush_nzcv", 64'(flags_nzcv), 64'h8);

    // Stalled ADDS with flush pulsed mid-stall, then release.
    setAlu(64'h1234, 4'b0110, 1'b1);
    stall = 1;
    applyStimulus();
    flush = 1;
    applyStimulus();
    flush = 0;
    applyStimulus();
    checkOutput("stall_nzcv", 64'(flags_nzcv), 64'h8);
    stall = 0;
    applyStimulus();
    checkOutput("release_nzcv", 64'(flags_nzcv), 64'h6);
    checkOutput("release_valid", 64'(mem_valid), 64'h1);
    clearInputs();
    applyStimulus();
    checkOutput("after_nzcv", 64'(flags_nzcv), 64'h6);

    // Random mix of instructions, stalls and flushes.
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 6);
      setAlu({$urandom, $urandom}, 4'($urandom), kind == 1);
      ex_store_data = {$urandom, $urandom};
      ex_branch_target = {$urandom, $urandom};
      ex_rd = 5'($urandom);
      ex_reg_write = 1'($urandom);
      ex_mem_read = 1'($urandom);
      ex_mem_write = 1'($urandom);
      ex_cond = 4'($urandom);
      ex_valid = (kind != 0);
      ex_is_b = (kind == 3);
      ex_is_cbz = (kind == 4);
      ex_is_cbnz = (kind == 5);
      ex_is_bcond = (kind == 6) || (kind == 2);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
